// File: rtl/ysyx_22050612_fetch_if.sv
// Fetch unit bus: memory request/response, decode hand-off, redirect.
// YSYX_22050612_FETCH_FAULT_EN adds rsp_err / inst_fault.
interface ysyx_22050612_fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_ready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
`ifdef YSYX_22050612_FETCH_FAULT_EN
  logic        rsp_err;
  logic        inst_fault;

  modport master (
    output req_valid, req_addr, rsp_ready,
    output inst_valid, inst, inst_pc, inst_fault,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    input  inst_valid, inst, inst_pc, inst_fault,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output inst_ready, redirect_valid, redirect_pc
  );
`else
  modport master (
    output req_valid, req_addr, rsp_ready,
    output inst_valid, inst, inst_pc,
    input  req_ready, rsp_valid, rsp_data,
    input  inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    input  inst_valid, inst, inst_pc,
    output req_ready, rsp_valid, rsp_data,
    output inst_ready, redirect_valid, redirect_pc
  );
`endif
endinterface

// File: rtl/ysyx_22050612_fetch.sv
// Instruction fetch: single-outstanding reader feeding a small FIFO.
// Optional YSYX_22050612_FETCH_FAULT_EN: bus errors become faulting nops.
module ysyx_22050612_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          DEPTH    = 2
) (
  input logic                   clk,
  input logic                   rst,
  ysyx_22050612_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] tag;
  logic [AW:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0] mem_inst [DEPTH];
  logic [63:0] mem_pc [DEPTH];

  logic hs;
  logic push;
  logic pop;
  logic redir;
  logic err;
  logic halt;

  assign redir = bus.redirect_valid;
  assign hs    = bus.req_valid & bus.req_ready;
  assign push  = (state == WAIT) & bus.rsp_valid & ~redir;
  assign pop   = bus.inst_valid & bus.inst_ready & ~redir;

  assign bus.req_valid  = (state == REQ) & (count < FULL) & ~halt;
  assign bus.req_addr   = pc;
  assign bus.rsp_ready  = 1'b1;
  assign bus.inst_valid = (count != '0);
  assign bus.inst       = mem_inst[rd_ptr];
  assign bus.inst_pc    = mem_pc[rd_ptr];

`ifdef YSYX_22050612_FETCH_FAULT_EN
  logic [DEPTH-1:0] mem_flt;

  assign err = bus.rsp_err;
  assign bus.inst_fault = mem_flt[rd_ptr];

  // A faulting fetch parks the unit until execute steers it elsewhere.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt    <= 1'b0;
      mem_flt <= '0;
    end else if (redir) begin
      halt <= 1'b0;
    end else if (push) begin
      mem_flt[wr_ptr] <= err;
      if (err) halt <= 1'b1;
    end
  end
`else
  assign err  = 1'b0;
  assign halt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      tag   <= '0;
    end else if (redir) begin
      pc <= {bus.redirect_pc[63:2], 2'b00};
      // An address issued this cycle or still in flight is stale.
      unique case (state)
        IDLE:    state <= IDLE;
        REQ:     state <= hs ? DROP : REQ;
        default: state <= bus.rsp_valid ? REQ : DROP;
      endcase
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (hs) begin
            pc    <= pc + 64'd4;
            tag   <= pc;
            state <= WAIT;
          end
        end
        WAIT: if (bus.rsp_valid) state <= REQ;
        DROP: if (bus.rsp_valid) state <= REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (redir) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem_inst[wr_ptr] <= err ? 32'h0000_0013 : bus.rsp_data;
        mem_pc[wr_ptr]   <= tag;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
endmodule
